// File: rtl/alu_4bit_if.sv
// Operand, control and status bundle for one 4-bit ALU slice.
interface alu_4bit_if;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       less;
    logic [2:0] op;
    logic [3:0] result;
    logic       cout;
    logic       G;
    logic       P;
    logic       set;
    logic       overflow;
    logic       zero;

    // Driver side: supplies operands and control, observes the slice outputs.
    modport master (
        output a, b, cin, less, op,
        input  result, cout, G, P, set, overflow, zero
    );

    // ALU slice side.
    modport slave (
        input  a, b, cin, less, op,
        output result, cout, G, P, set, overflow, zero
    );
endinterface

// File: rtl/alu_4bit.sv
// 4-bit ALU slice: AND / OR / ADD-SUB / SLT with carry-lookahead group
// outputs and a combinational set bit for SLT cascading. Result and flags
// are registered with one cycle of latency.
module alu_4bit (
    input  logic     clk,
    input  logic     rst,
    alu_4bit_if.slave bus
);

    logic [3:0] bb;
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] sum;
    logic [3:0] result_next;
    logic       c0, c1, c2, c3, c4;
    logic       ovf_n;

    // Operand conditioning, bitwise terms and flattened lookahead carries.
    always_comb begin
        bb  = bus.op[2] ? ~bus.b : bus.b;
        p   = bus.a ^ bb;
        g   = bus.a & bb;
        c0  = bus.cin;
        c1  = g[0] | (p[0] & c0);
        c2  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                   | (p[2] & p[1] & p[0] & c0);
        c4  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                   | (p[3] & p[2] & p[1] & g[0])
                   | (p[3] & p[2] & p[1] & p[0] & c0);
        sum   = p ^ {c3, c2, c1, c0};
        ovf_n = c4 ^ c3;
    end

    // Group terms exclude cin so an external lookahead unit can combine slices.
    assign bus.P   = &p;
    assign bus.G   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                   | (p[3] & p[2] & p[1] & g[0]);
    // True sign of the signed sum; never looks at less, so less may be tied to it.
    assign bus.set = sum[3] ^ ovf_n;

    // Result mux by operation.
    always_comb begin
        result_next = 4'b0000;
        unique case (bus.op[1:0])
            2'b00:   result_next = bus.a & bb;
            2'b01:   result_next = bus.a | bb;
            2'b10:   result_next = sum;
            2'b11:   result_next = {3'b000, bus.less};
            default: result_next = 4'b0000;
        endcase
    end

    // Output registers; reset wins over any input activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.result   <= 4'b0000;
            bus.cout     <= 1'b0;
            bus.overflow <= 1'b0;
            bus.zero     <= 1'b1;
        end else begin
            bus.result   <= result_next;
            bus.cout     <= c4;
            bus.overflow <= ovf_n;
            bus.zero     <= (result_next == 4'b0000);
        end
    end

endmodule

// File: tb/tb_alu_4bit.sv
// Self-checking bench for alu_4bit: directed vectors plus random stimulus
// against an integer-arithmetic reference model.
module tb_alu_4bit;

    logic clk;
    logic rst;
    logic tie_mode;
    logic less_drv;
    int   errors;
    int   checks;

    alu_4bit_if bus ();

    alu_4bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Standalone SLT: less fed back from set when tie_mode is high.
    assign bus.less = tie_mode ? bus.set : less_drv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one vector, check combinational outputs, clock it, check registers.
    task automatic step(input logic [3:0] ta, input logic [3:0] tbv, input logic [2:0] top,
                        input logic tcin, input logic tless, input logic ttie, input logic trst);
        int bbi, usum, sa, sb, ssum, res;
        logic e_set, e_ovf, e_cout, e_g, e_p, lessv;
        bus.a    = ta;
        bus.b    = tbv;
        bus.op   = top;
        bus.cin  = tcin;
        less_drv = tless;
        tie_mode = ttie;
        rst      = trst;

        bbi  = top[2] ? (15 - int'(tbv)) : int'(tbv);
        usum = int'(ta) + bbi + int'(tcin);
        sa   = (int'(ta) >= 8) ? int'(ta) - 16 : int'(ta);
        sb   = (bbi >= 8) ? bbi - 16 : bbi;
        ssum = sa + sb + int'(tcin);
        e_ovf  = (ssum < -8) || (ssum > 7);
        e_set  = (ssum < 0);
        e_cout = (usum >= 16);
        e_g    = ((int'(ta) + bbi) >= 16);
        e_p    = ((int'(ta) ^ bbi) == 15);
        lessv  = ttie ? e_set : tless;
        case (top[1:0])
            2'b00:   res = int'(ta) & bbi;
            2'b01:   res = int'(ta) | bbi;
            2'b10:   res = usum % 16;
            default: res = int'(lessv);
        endcase

        #1;
        check("set", {3'b000, bus.set}, {3'b000, e_set});
        check("G",   {3'b000, bus.G},   {3'b000, e_g});
        check("P",   {3'b000, bus.P},   {3'b000, e_p});
        @(posedge clk);
        #1;
        if (trst) begin
            check("rst_result",   bus.result,             4'b0000);
            check("rst_cout",     {3'b000, bus.cout},     4'b0000);
            check("rst_overflow", {3'b000, bus.overflow}, 4'b0000);
            check("rst_zero",     {3'b000, bus.zero},     4'b0001);
        end else begin
            check("result",   bus.result,             4'(res));
            check("cout",     {3'b000, bus.cout},     {3'b000, e_cout});
            check("overflow", {3'b000, bus.overflow}, {3'b000, e_ovf});
            check("zero",     {3'b000, bus.zero},     {3'b000, (res == 0)});
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst      = 1'b1;
        tie_mode = 1'b0;
        less_drv = 1'b0;
        bus.a    = 4'h0;
        bus.b    = 4'h0;
        bus.op   = 3'b000;
        bus.cin  = 1'b0;
        @(posedge clk);
        #1;

        // Reset with arbitrary inputs.
        step(4'hA, 4'h7, 3'b010, 1'b1, 1'b1, 1'b0, 1'b1);
        step(4'hF, 4'hF, 3'b011, 1'b0, 1'b1, 1'b0, 1'b1);

        // AND with B-invert.
        step(4'b1111, 4'b0010, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0);
        check("tp_and_inv", bus.result, 4'b1101);

        // ADD.
        step(4'b0111, 4'b0111, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        check("tp_add_pos_ovf", {bus.result[3:1], bus.overflow}, 4'b1111);
        step(4'b1000, 4'b1000, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        check("tp_add_neg_ovf", {bus.cout, bus.overflow, bus.zero, 1'b0}, 4'b1110);
        step(4'b1001, 4'b0111, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        check("tp_add_wrap", {bus.cout, bus.overflow, bus.zero, 1'b0}, 4'b1010);

        // SUB.
        step(4'b0111, 4'b0111, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0);
        step(4'b1001, 4'b0111, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0);
        check("tp_sub_ovf", bus.result, 4'b0010);
        step(4'b1001, 4'b1001, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0);

        // SLT with less tied to set.
        step(4'b0000, 4'b0001, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0);
        check("tp_slt_0_1", bus.result, 4'b0001);
        step(4'b0001, 4'b0000, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0);
        check("tp_slt_1_0", bus.result, 4'b0000);
        step(4'b1001, 4'b1111, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0);
        check("tp_slt_m7_m1", bus.result, 4'b0001);
        step(4'b1111, 4'b1001, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0);
        check("tp_slt_m1_m7", bus.result, 4'b0000);
        step(4'b1111, 4'b0000, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0);
        check("tp_slt_m1_0", bus.result, 4'b0001);

        // Group propagate/generate example, OR and OR-invert.
        step(4'b0101, 4'b1010, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        check("tp_gp", {2'b00, bus.P, bus.G}, 4'b0010);
        step(4'b0101, 4'b0011, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        step(4'b0101, 4'b0011, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0);
        // SLT with less driven directly (slice in a wider ALU).
        step(4'b0000, 4'b0000, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset mid-stream, then resume.
        step(4'b0111, 4'b0011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
        step(4'b0111, 4'b0011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back random vectors, occasional reset and less tie.
        for (int i = 0; i < 300; i++) begin
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_4bit.md
Name:
alu_4bit

Overview:
- 4-bit ALU slice with AND, OR, ADD/SUB and set-less-than (SLT) operations.
- Provides group generate/propagate outputs for a carry-lookahead unit, plus a combinational set output for SLT cascading.
- Used standalone (less tied back to set) or as one slice of a wider ALU.
- Result and status flags are registered, with one-cycle latency.

Parameters:
- None. Width is fixed at 4.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- a  in  4  operand A, two's complement.
- b  in  4  operand B, two's complement.
- cin  in  1  adder carry-in. Driven equal to op[2] for SUB and SLT.
- less  in  1  value placed on result[0] in SLT mode. Tie to set for standalone use.
- op  in  3  op[2] selects B-invert; op[1:0]: 00 AND, 01 OR, 10 ADD, 11 SLT.
- result  out  4  registered ALU result.
- cout  out  1  registered adder carry-out.
- G  out  1  combinational group generate.
- P  out  1  combinational group propagate.
- set  out  1  combinational signed less-than (adder MSB XOR overflow).
- overflow  out  1  registered signed overflow of the adder.
- zero  out  1  registered flag, high when result is 0000.

Behaviour:
- Datapath (all combinational):
  - bb = op[2] ? ~b : b.
  - Bitwise terms: p_i = a_i ^ bb_i, g_i = a_i & bb_i.
  - Carry lookahead: c0 = cin, c(i+1) = g_i | p_i & c_i.
  - Sum: sum_i = p_i ^ c_i.
  - Carry-out: cout_n = c4.
  - Overflow: ovf_n = c4 ^ c3.
- Group outputs:
  - P = p3 & p2 & p1 & p0.
  - G = g3 | p3g2 | p3p2g1 | p3p2p1g0.
  - Both independent of cin.
- set = sum3 ^ ovf_n. It depends only on a, b, op[2] and cin, never on less, so tying less to set forms no combinational loop.
- Result select:
  - AND: a & bb.
  - OR: a | bb.
  - ADD: sum.
  - SLT: {3'b000, less}.
- cout and overflow always report the adder, whatever the op.
- Registers, on each rising clk:
  - rst=1: result=0000, cout=0, overflow=0, zero=1.
  - Otherwise: result, cout, overflow load the next values computed from the inputs at that edge; zero loads (next result == 0).
- Latency:
  - Registered outputs: exactly one cycle.
  - G, P, set: zero-cycle, with no reset dependence.
- Reset has priority over any input activity. Reset asserted mid-stream clears the registers on that edge; the first valid result appears one edge after rst deasserts.
- Wrap-around: unsigned overflow wraps modulo 16, reported via cout.
- Signed range is -8..7. overflow is set when two same-sign operands (after the B-invert) produce the opposite-sign sum.
- op[2]=1 with op[1:0]=00/01 yields a & ~b or a | ~b.
- cin is not forced by op; the user drives it.

Test Plan:
- Reset: assert rst with arbitrary inputs -> after the edge result=0000, cout=0, overflow=0, zero=1.
- AND with B-invert: a=1111, b=0010, op=100, cin=1 -> next cycle result=1101, zero=0, cout=1, overflow=0.
- ADD:
  - a=0111, b=0111, op=010, cin=0 -> result=1110, overflow=1, cout=0, set=0.
  - a=1000, b=1000 -> result=0000, cout=1, overflow=1, zero=1.
  - a=1001, b=0111 -> result=0000, cout=1, overflow=0, zero=1.
- SUB (op=110, cin=1):
  - a=0111, b=0111 -> result=0000, zero=1, cout=1, overflow=0.
  - a=1001, b=0111 -> result=0010, overflow=1, set=1.
  - a=1001, b=1001 -> result=0000, zero=1.
- SLT (op=111, cin=1, less tied to set):
  - 0000 vs 0001 -> 0001.
  - 0001 vs 0000 -> 0000, zero=1.
  - 1001 vs 1111 -> 0001.
  - 1111 vs 1001 -> 0000.
  - 1111 vs 0000 -> 0001.
- Back-to-back: change inputs every cycle -> each result matches the previous cycle's inputs. G and P match the formulas, e.g. a=0101, b=1010, op=010 gives P=1, G=0.
